// File: rtl/izhikevich_array.sv
// izhikevich_array: time-multiplexed array of Izhikevich neurons on one fixed-point datapath.
// Optional per-neuron spike counters when SPIKE_COUNT_EN is defined.
module izhikevich_array #(
   parameter int WIDTH     = 17,
   parameter int FRAC      = 8,
   parameter int N_NEURONS = 8,
   parameter int ADDR_W    = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     step,
   output logic                     busy,
   output logic                     step_done,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [WIDTH-1:0]  in_i,
   output logic                     spike_valid,
   output logic [ADDR_W-1:0]        spike_idx,
   input  logic                     cfg_we,
   input  logic [ADDR_W-1:0]        cfg_addr,
   input  logic [2:0]               cfg_sel,
   input  logic signed [WIDTH-1:0]  cfg_data,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic signed [WIDTH-1:0]  rd_v,
   output logic signed [WIDTH-1:0]  rd_u,
   output logic [15:0]              rd_cnt
);
   localparam int SW = WIDTH + 4;
   localparam int PW = 2 * WIDTH;
   localparam int QW = 3 * WIDTH;
   localparam int IW = N_NEURONS > 1 ? $clog2(N_NEURONS) : 1;
   localparam logic signed [WIDTH-1:0] K004  = WIDTH'((4 * (1 << FRAC) + 50) / 100);
   localparam logic signed [WIDTH-1:0] K5    = WIDTH'(5 * (1 << FRAC));
   localparam logic signed [WIDTH-1:0] K140  = WIDTH'(140 * (1 << FRAC));
   localparam logic signed [WIDTH-1:0] VPEAK = WIDTH'(30 * (1 << FRAC));
   localparam logic signed [SW-1:0] HI = {{5{1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] LO = {{5{1'b1}}, {(WIDTH-1){1'b0}}};

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [SW-1:0] x);
      return x > HI ? HI[WIDTH-1:0] : x < LO ? LO[WIDTH-1:0] : x[WIDTH-1:0];
   endfunction

   typedef enum logic [2:0] {IDLE, WAIT_I, CALC, WB, DONE} state_t;
   state_t st, nxt;

   logic signed [WIDTH-1:0] a_bank [N_NEURONS];
   logic signed [WIDTH-1:0] b_bank [N_NEURONS];
   logic signed [WIDTH-1:0] c_bank [N_NEURONS];
   logic signed [WIDTH-1:0] d_bank [N_NEURONS];
   logic signed [WIDTH-1:0] v_bank [N_NEURONS];
   logic signed [WIDTH-1:0] u_bank [N_NEURONS];
   logic [ADDR_W-1:0] idx;
   logic signed [WIDTH-1:0] cur_i, nv_r, nu_r;
   logic fire_r;

   logic [IW-1:0] idx_i, cfg_i, rd_i;
   logic last, cfg_hit, rd_ok;
   assign idx_i   = idx[IW-1:0];
   assign cfg_i   = cfg_addr[IW-1:0];
   assign rd_i    = rd_addr[IW-1:0];
   assign last    = idx == ADDR_W'(N_NEURONS - 1);
   assign cfg_hit = st == IDLE && cfg_we && {1'b0, cfg_addr} < (ADDR_W+1)'(N_NEURONS);
   assign rd_ok   = {1'b0, rd_addr} < (ADDR_W+1)'(N_NEURONS);

   logic signed [WIDTH-1:0] a0, b0, c0, d0, v0, u0, vn, un, ud, w;
   logic signed [PW-1:0] p1, p3, pb, pa;
   logic signed [QW-1:0] p2;
   logic fire;
   assign a0 = a_bank[idx_i];
   assign b0 = b_bank[idx_i];
   assign c0 = c_bank[idx_i];
   assign d0 = d_bank[idx_i];
   assign v0 = v_bank[idx_i];
   assign u0 = u_bank[idx_i];
   // v' = 0.04v^2 + 5v + 140 - u + I, with 0.04v^2 built as two floor-shifted products
   assign p1 = PW'(K004) * PW'(v0);
   assign p2 = QW'(p1 >>> FRAC) * QW'(v0);
   assign p3 = PW'(K5) * PW'(v0);
   assign vn = sat(SW'(v0) + SW'(p2 >>> FRAC) + SW'(p3 >>> FRAC) + SW'(K140) - SW'(u0) + SW'(cur_i));
   assign pb = PW'(b0) * PW'(v0);
   assign w  = sat(SW'(pb >>> FRAC) - SW'(u0));
   assign pa = PW'(a0) * PW'(w);
   assign un = sat(SW'(u0) + SW'(pa >>> FRAC));
   assign ud = sat(SW'(u0) + SW'(d0));
   assign fire = vn >= VPEAK;

   always_ff @(posedge clk or posedge rst)
      if (rst) st <= IDLE;
      else st <= nxt;

   always_comb begin
      nxt = st;
      case (st)
         IDLE:    nxt = step ? WAIT_I : IDLE;
         WAIT_I:  nxt = in_valid ? CALC : WAIT_I;
         CALC:    nxt = WB;
         WB:      nxt = last ? DONE : WAIT_I;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   assign busy        = st != IDLE;
   assign step_done   = st == DONE;
   assign in_ready    = st == WAIT_I;
   assign spike_valid = st == WB && fire_r;
   assign spike_idx   = idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_NEURONS; k++) begin
            a_bank[k] <= '0;
            b_bank[k] <= '0;
            c_bank[k] <= '0;
            d_bank[k] <= '0;
            v_bank[k] <= '0;
            u_bank[k] <= '0;
         end
         idx    <= '0;
         cur_i  <= '0;
         nv_r   <= '0;
         nu_r   <= '0;
         fire_r <= 1'b0;
         rd_v   <= '0;
         rd_u   <= '0;
      end else begin
         if (st == IDLE && step) idx <= '0;
         if (st == WAIT_I && in_valid) cur_i <= in_i;
         if (st == CALC) begin
            nv_r   <= fire ? c0 : vn;
            nu_r   <= fire ? ud : un;
            fire_r <= fire;
         end
         if (st == WB) begin
            v_bank[idx_i] <= nv_r;
            u_bank[idx_i] <= nu_r;
            if (!last) idx <= idx + ADDR_W'(1);
         end
         if (cfg_hit)
            case (cfg_sel)
               3'd0: a_bank[cfg_i] <= cfg_data;
               3'd1: b_bank[cfg_i] <= cfg_data;
               3'd2: c_bank[cfg_i] <= cfg_data;
               3'd3: d_bank[cfg_i] <= cfg_data;
               3'd4: v_bank[cfg_i] <= cfg_data;
               3'd5: u_bank[cfg_i] <= cfg_data;
               default: ;
            endcase
         rd_v <= rd_ok ? v_bank[rd_i] : '0;
         rd_u <= rd_ok ? u_bank[rd_i] : '0;
      end
   end

`ifdef SPIKE_COUNT_EN
   logic [15:0] cnt [N_NEURONS];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_NEURONS; k++) cnt[k] <= '0;
         rd_cnt <= '0;
      end else begin
         if (st == WB && fire_r && cnt[idx_i] != 16'hFFFF) cnt[idx_i] <= cnt[idx_i] + 16'd1;
         if (cfg_hit && cfg_sel == 3'd4) cnt[cfg_i] <= '0;
         rd_cnt <= rd_ok ? cnt[rd_i] : '0;
      end
   end
`else
   assign rd_cnt = '0;
`endif
endmodule

// File: tb/tb_izhikevich_array.sv
// tb_izhikevich_array: directed checks of the neuron array with hand-computed expectations.
module tb_izhikevich_array;
   localparam int N = 8;
   localparam int AW = 4;
   logic clk = 1'b0, rst = 1'b1, step = 1'b0, in_valid = 1'b0, cfg_we = 1'b0;
   logic busy, step_done, in_ready, spike_valid;
   logic [AW-1:0] spike_idx, cfg_addr = '0, rd_addr = '0;
   logic signed [16:0] in_i = '0, cfg_data = '0, rd_v, rd_u;
   logic [2:0] cfg_sel = '0;
   logic [15:0] rd_cnt;
   int n_vec = 0, n_err = 0;
   int cur [N];
   int cyc, ndone, done_at, stall_seen, rv, ru, rc, hs_cnt;
   logic [15:0] mask;

   izhikevich_array #(.WIDTH(17), .FRAC(8), .N_NEURONS(N), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .step(step), .busy(busy), .step_done(step_done),
      .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i),
      .spike_valid(spike_valid), .spike_idx(spike_idx),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
      .rd_addr(rd_addr), .rd_v(rd_v), .rd_u(rd_u), .rd_cnt(rd_cnt)
   );

   always #5 clk = ~clk;

`ifdef SPIKE_COUNT_EN
   localparam int CNT1 = 1;
`else
   localparam int CNT1 = 0;
`endif

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cfg(input int addr, input int sel, input int data);
      cfg_addr = AW'(addr);
      cfg_sel  = 3'(sel);
      cfg_data = 17'(data);
      cfg_we   = 1'b1;
      @(posedge clk); #1;
      cfg_we   = 1'b0;
   endtask

   task automatic rd(input int addr, output int v, output int u, output int c);
      rd_addr = AW'(addr);
      @(posedge clk); #1;
      v = rd_v;
      u = rd_u;
      c = rd_cnt;
   endtask

   // every neuron at rest: a=0.02 b=0.2 c=-65 d=8 v=-65 u=-13
   task automatic init_all();
      for (int n = 0; n < N; n++) begin
         cfg(n, 0, 5);
         cfg(n, 1, 51);
         cfg(n, 2, -16640);
         cfg(n, 3, 2048);
         cfg(n, 4, -16640);
         cfg(n, 5, -3328);
         cur[n] = 0;
      end
   endtask

   task automatic run_step(input int stall_at, input int stall_n, input int poke_at,
                           output int c, output int nd, output int d_at, output int ss,
                           output logic [15:0] m);
      int k, st;
      bit hs;
      k = 0; st = 0; c = 0; nd = 0; d_at = -1; ss = 0; m = '0;
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      while (busy && c < 200) begin
         cfg_we = (c == poke_at); step = (c == poke_at);
         cfg_addr = 4'd1; cfg_sel = 3'd4; cfg_data = 17'sd1234;
         in_valid = 1'b0;
         if (in_ready && k < N) begin
            if (k == stall_at && st < stall_n) begin st++; ss++; end
            else begin in_valid = 1'b1; in_i = 17'(cur[k]); end
         end
         hs = in_valid && in_ready;
         if (spike_valid) m[spike_idx] = 1'b1;
         if (step_done) begin nd++; d_at = c; end
         @(posedge clk); #1;
         c++;
         if (hs) k++;
      end
      cfg_we = 1'b0; step = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", step_done, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_spike", spike_valid, 0);
      chk("rst_sidx", spike_idx, 0);
      chk("rst_rdv", rd_v, 0);
      chk("rst_rdu", rd_u, 0);
      chk("rst_cnt", rd_cnt, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // rest neuron: no spike, v=-18422, u unchanged
      init_all();
      run_step(-1, 0, -1, cyc, ndone, done_at, stall_seen, mask);
      chk("t1_cycles", cyc, 3 * N + 1);
      chk("t1_ndone", ndone, 1);
      chk("t1_done_at", done_at, 3 * N);
      chk("t1_mask", mask, 0);
      rd(0, rv, ru, rc);
      chk("t1_v0", rv, -18422);
      chk("t1_u0", ru, -3328);
      rd(7, rv, ru, rc);
      chk("t1_v7", rv, -18422);
      chk("t1_u7", ru, -3328);

      // spike with saturated vn on neuron 0
      init_all();
      cfg(0, 4, 7424);
      cfg(0, 5, 0);
      cur[0] = 5120;
      run_step(-1, 0, -1, cyc, ndone, done_at, stall_seen, mask);
      chk("t2_mask", mask, 1);
      chk("t2_cycles", cyc, 3 * N + 1);
      rd(0, rv, ru, rc);
      chk("t2_v0", rv, -16640);
      chk("t2_u0", ru, 2048);
      chk("t2_cnt0", rc, CNT1);
      rd(1, rv, ru, rc);
      chk("t2_v1", rv, -18422);
      chk("t2_cnt1", rc, 0);

      // backpressure at neuron 3 for 5 cycles
      init_all();
      run_step(3, 5, -1, cyc, ndone, done_at, stall_seen, mask);
      chk("t3_cycles", cyc, 3 * N + 6);
      chk("t3_stall", stall_seen, 5);
      chk("t3_ndone", ndone, 1);
      chk("t3_mask", mask, 0);
      rd(3, rv, ru, rc);
      chk("t3_v3", rv, -18422);

      // cfg write and second step during a sweep are ignored
      init_all();
      run_step(-1, 0, 4, cyc, ndone, done_at, stall_seen, mask);
      chk("t4_cycles", cyc, 3 * N + 1);
      chk("t4_ndone", ndone, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_idle", busy, 0);
      rd(1, rv, ru, rc);
      chk("t4_v1", rv, -18422);
      chk("t4_u1", ru, -3328);

      // reset in neuron 4's CALC cycle
      init_all();
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      in_valid = 1'b1;
      in_i = '0;
      hs_cnt = 0;
      cyc = 0;
      while (hs_cnt < 5 && cyc < 100) begin
         bit hs;
         hs = in_ready;
         @(posedge clk); #1;
         cyc++;
         if (hs) hs_cnt++;
      end
      in_valid = 1'b0;
      chk("t5_reach", hs_cnt, 5);
      chk("t5_pre_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_done", step_done, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      ndone = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (step_done || busy) ndone++;
      end
      chk("t5_quiet", ndone, 0);
      for (int n = 0; n < N; n++) begin
         rd(n, rv, ru, rc);
         chk($sformatf("t5_v%0d", n), rv, 0);
         chk($sformatf("t5_u%0d", n), ru, 0);
      end

      // out-of-range cfg write and read
      cfg(0, 4, 777);
      cfg(N, 4, 999);
      cfg(N, 5, 555);
      rd(0, rv, ru, rc);
      chk("t6_v0", rv, 777);
      chk("t6_u0", ru, 0);
      rd(N, rv, ru, rc);
      chk("t6_rdv_oob", rv, 0);
      chk("t6_rdu_oob", ru, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
